// File: rtl/train_sample_sequencer_if.sv
// Sequencer-side bundle: buffer load, run control and the
// per-sample feature/target handshake toward the training FSM.
interface train_sample_sequencer_if #(
  parameter int IDX_W = 3
);
  logic             load_i;
  logic [7:0]       data_i;
  logic             clear_i;
  logic             start_i;
  logic [7:0]       epochs_i;
  logic             pass_done_i;
  logic [3:0]       x_o;
  logic [3:0]       target_o;
  logic             init_o;
  logic             busy_o;
  logic             done_o;
  logic [IDX_W:0]   count_o;
  logic [IDX_W-1:0] sample_idx_o;
  logic [7:0]       epoch_o;
  logic             overflow_o;

  modport master (
    output load_i, data_i, clear_i, start_i,
    output epochs_i, pass_done_i,
    input  x_o, target_o, init_o, busy_o, done_o,
    input  count_o, sample_idx_o, epoch_o, overflow_o
  );

  modport slave (
    input  load_i, data_i, clear_i, start_i,
    input  epochs_i, pass_done_i,
    output x_o, target_o, init_o, busy_o, done_o,
    output count_o, sample_idx_o, epoch_o, overflow_o
  );
endinterface

// File: rtl/train_sample_sequencer.sv
// Buffers byte-wise training samples and replays them per epoch,
// issuing one init pulse per sample and waiting for pass completion.
module train_sample_sequencer #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input logic                    clk_i,
  input logic                    rst_i,
  train_sample_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [IDX_W:0]   FULL = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] INC  = IDX_W'(1);

  state_t           r_state;
  state_t           w_nxt;
  logic [7:0]       r_mem [DEPTH];
  logic [IDX_W:0]   r_count;
  logic             r_ovf;
  logic [7:0]       r_epochs;
  logic [7:0]       r_epoch;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_x;
  logic [3:0]       r_t;

  logic             w_clr;
  logic             w_start;
  logic             w_load;
  logic             w_adv;
  logic             w_last;
  logic             w_full;
  logic [7:0]       w_ep_inc;
  logic [IDX_W-1:0] w_ridx;
  logic [IDX_W-1:0] w_rd;
  logic [7:0]       w_rdat;

  always_comb begin
    w_nxt    = r_state;
    w_clr    = 1'b0;
    w_start  = 1'b0;
    w_load   = 1'b0;
    w_adv    = 1'b0;
    w_full   = (r_count == FULL);
    w_last   = ({1'b0, r_idx} == (r_count - ONE));
    w_ep_inc = r_epoch + 8'd1;
    w_ridx   = w_last ? '0 : (r_idx + INC);
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.clear_i) begin
          w_clr = 1'b1;
          w_nxt = S_IDLE;
        end else if (bus.start_i && (r_count != '0)
                     && (bus.epochs_i != 8'd0)) begin
          w_start = 1'b1;
          w_nxt   = S_ISSUE;
        end else if ((r_state == S_IDLE) && bus.load_i) begin
          w_load = 1'b1;
        end
      end
      S_ISSUE: w_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.pass_done_i) w_nxt = S_NEXT;
      end
      S_NEXT: begin
        w_adv = 1'b1;
        if (w_last && (w_ep_inc == r_epochs)) w_nxt = S_DONE;
        else w_nxt = S_ISSUE;
      end
      default: w_nxt = S_IDLE;
    endcase
    // one read port serves both the run start and the advance
    w_rd   = w_start ? '0 : w_ridx;
    w_rdat = r_mem[w_rd];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_epochs <= '0;
      r_epoch  <= '0;
      r_idx    <= '0;
      r_x      <= '0;
      r_t      <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_clr) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
        r_epoch <= '0;
        r_idx   <= '0;
      end
      if (w_load) begin
        if (w_full) r_ovf <= 1'b1;
        else r_count <= r_count + ONE;
      end
      if (w_start) begin
        r_epochs <= bus.epochs_i;
        r_idx    <= '0;
        r_epoch  <= '0;
        r_x      <= w_rdat[3:0];
        r_t      <= w_rdat[7:4];
      end
      if (w_adv) begin
        r_idx <= w_ridx;
        if (w_last) r_epoch <= w_ep_inc;
        if (w_nxt == S_ISSUE) begin
          r_x <= w_rdat[3:0];
          r_t <= w_rdat[7:4];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_load && !w_full)
      r_mem[r_count[IDX_W-1:0]] <= bus.data_i;
  end

  assign bus.x_o          = r_x;
  assign bus.target_o     = r_t;
  assign bus.init_o       = (r_state == S_ISSUE);
  assign bus.busy_o       = (r_state == S_ISSUE) || (r_state == S_WAIT)
                            || (r_state == S_NEXT);
  assign bus.done_o       = (r_state == S_DONE);
  assign bus.count_o      = r_count;
  assign bus.sample_idx_o = r_idx;
  assign bus.epoch_o      = r_epoch;
  assign bus.overflow_o   = r_ovf;
endmodule

// File: tb/tb_train_sample_sequencer.sv
// Bench for train_sample_sequencer: vector table for load/control,
// replay runs checked against a queue model of the sample buffer.
module tb_train_sample_sequencer;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  train_sample_sequencer_if #(.IDX_W(IDX_W)) bus ();

  train_sample_sequencer #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  typedef struct {
    bit         ld;
    logic [7:0] d;
    bit         clr;
    bit         st;
    logic [7:0] ep;
    bit         pd;
    int         cnt;
    bit         ovf;
    bit         busy;
    bit         init;
    bit         done;
  } vec_t;

  vec_t       tbl [14];
  logic [7:0] q [$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.load_i      = 1'b0;
    bus.data_i      = 8'h00;
    bus.clear_i     = 1'b0;
    bus.start_i     = 1'b0;
    bus.epochs_i    = 8'h00;
    bus.pass_done_i = 1'b0;
  endtask

  task automatic apply_vec(input int i);
    bus.load_i      = tbl[i].ld;
    bus.data_i      = tbl[i].d;
    bus.clear_i     = tbl[i].clr;
    bus.start_i     = tbl[i].st;
    bus.epochs_i    = tbl[i].ep;
    bus.pass_done_i = tbl[i].pd;
    tick();
    idle_inputs();
    chk($sformatf("v%0d_count", i), int'(bus.count_o), tbl[i].cnt);
    chk($sformatf("v%0d_ovf", i), int'(bus.overflow_o), int'(tbl[i].ovf));
    chk($sformatf("v%0d_busy", i), int'(bus.busy_o), int'(tbl[i].busy));
    chk($sformatf("v%0d_init", i), int'(bus.init_o), int'(tbl[i].init));
    chk($sformatf("v%0d_done", i), int'(bus.done_o), int'(tbl[i].done));
  endtask

  task automatic load_byte(input logic [7:0] d);
    bus.load_i = 1'b1;
    bus.data_i = d;
    tick();
    bus.load_i = 1'b0;
    if (q.size() < DEPTH) q.push_back(d);
  endtask

  task automatic do_clear();
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    q.delete();
  endtask

  // Expected replay: the buffered samples, in order, ep times over.
  task automatic run_train(input int ep, input int dmin, input int dmax,
                           input bit inj, input bit gapchk);
    int n, total, c0, last_c, d, sz;
    logic [7:0] s;
    sz     = q.size();
    total  = ep * sz;
    n      = 0;
    last_c = -1;
    bus.start_i  = 1'b1;
    bus.epochs_i = 8'(ep);
    tick();
    bus.start_i = 1'b0;
    c0 = cyc;
    chk("start_init", int'(bus.init_o), 1);
    chk("start_done_drop", int'(bus.done_o), 0);
    while (!bus.done_o && (cyc - c0) < 3000) begin
      if (bus.init_o) begin
        s = (n < total) ? q[n % sz] : 8'h00;
        if (n < total) begin
          chk("x", int'(bus.x_o), int'(s[3:0]));
          chk("target", int'(bus.target_o), int'(s[7:4]));
          chk("sample_idx", int'(bus.sample_idx_o), n % sz);
          chk("epoch_mid", int'(bus.epoch_o), n / sz);
        end
        if (gapchk && last_c >= 0) chk("init_gap", cyc - last_c, 3);
        last_c = cyc;
        n++;
        tick();
        if (inj && n == 1) begin
          bus.load_i   = 1'b1;
          bus.data_i   = 8'hEE;
          bus.clear_i  = 1'b1;
          bus.start_i  = 1'b1;
          bus.epochs_i = 8'd7;
          tick();
          idle_inputs();
          chk("inj_count", int'(bus.count_o), sz);
          chk("inj_busy", int'(bus.busy_o), 1);
          chk("inj_hold_x", int'(bus.x_o), int'(s[3:0]));
        end
        d = $urandom_range(dmax, dmin);
        repeat (d) tick();
        chk("wait_no_init", int'(bus.init_o), 0);
        bus.pass_done_i = 1'b1;
        tick();
        bus.pass_done_i = 1'b0;
        tick();
      end else begin
        tick();
      end
    end
    chk("init_pulses", n, total);
    chk("run_done", int'(bus.done_o), 1);
    chk("run_epoch", int'(bus.epoch_o), ep);
    chk("run_busy", int'(bus.busy_o), 0);
    chk("run_init", int'(bus.init_o), 0);
    if (total > 0) begin
      s = q[sz - 1];
      chk("done_hold_x", int'(bus.x_o), int'(s[3:0]));
    end
  endtask

  initial begin
    int nl, ep;
    idle_inputs();
    tbl[0] = '{0, 8'h00, 0, 1, 8'd3, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 8'h00, 0, 0, 8'd0, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++)
      tbl[2+i] = '{1, 8'(8'h10 + i), 0, 0, 8'd0, 0,
                   (i < 8) ? i + 1 : 8, (i == 8), 0, 0, 0};
    tbl[11] = '{0, 8'h00, 0, 1, 8'd0, 0, 8, 1, 0, 0, 0};
    tbl[12] = '{1, 8'h99, 1, 1, 8'd1, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{1, 8'h55, 0, 1, 8'd0, 0, 1, 0, 0, 0, 0};

    repeat (2) tick();
    chk("rst_init", int'(bus.init_o), 0);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_done", int'(bus.done_o), 0);
    chk("rst_count", int'(bus.count_o), 0);
    chk("rst_x", int'(bus.x_o), 0);
    chk("rst_ovf", int'(bus.overflow_o), 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) apply_vec(i);
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(8'(8'h10 + i));
    run_train(1, 0, 2, 0, 0);
    apply_vec(12);
    q.delete();
    apply_vec(13);
    do_clear();

    load_byte(8'h21);
    load_byte(8'h43);
    load_byte(8'h65);
    run_train(2, 3, 3, 1, 0);
    run_train(1, 0, 0, 0, 1);

    do_clear();
    load_byte(8'hAB);
    load_byte(8'hCD);
    bus.start_i  = 1'b1;
    bus.epochs_i = 8'd4;
    tick();
    bus.start_i = 1'b0;
    tick();
    chk("pre_rst_busy", int'(bus.busy_o), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    chk("mid_rst_busy", int'(bus.busy_o), 0);
    chk("mid_rst_x", int'(bus.x_o), 0);
    chk("mid_rst_tgt", int'(bus.target_o), 0);
    chk("mid_rst_count", int'(bus.count_o), 0);
    chk("mid_rst_init", int'(bus.init_o), 0);
    chk("mid_rst_epoch", int'(bus.epoch_o), 0);

    for (int it = 0; it < 6; it++) begin
      do_clear();
      nl = $urandom_range(10, 1);
      for (int k = 0; k < nl; k++) load_byte(8'($urandom));
      chk("rnd_count", int'(bus.count_o), (nl < DEPTH) ? nl : DEPTH);
      chk("rnd_ovf", int'(bus.overflow_o), int'(nl > DEPTH));
      ep = $urandom_range(3, 1);
      run_train(ep, 0, 4, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
